tmr_shift_ctrl: RTL and testbench

Command sequencer for the triplicated 128-bit shift register (three register copies plus majority voter). Accepts word-level commands over a valid/ready interface and drives the register's enable/mode/load/serial_in/parallel_in, so the register transmits or receives 1..width bits serially, or is written and read in parallel. Sits between the system-side command bus and the register top; one command is in flight at a time, and each command returns exactly one response.

---
 rtl/tmr_shift_pkg.sv | 72 +++++++
 rtl/tmr_shift_ctrl_if.sv | 25 ++
 rtl/tmr_shift_ctrl.sv | 145 ++++++++++++++
 tb/tb_tmr_shift_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tmr_shift_pkg.sv
// Shared types and control-word helper for the triplicated shift register sequencer.
package tmr_shift_pkg;

    typedef enum logic [1:0] {
        OP_TX    = 2'b00,
        OP_RX    = 2'b01,
        OP_WRITE = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_SR   = 2'b00;
    localparam logic [1:0] MODE_SL   = 2'b01;
    localparam logic [1:0] MODE_PISO = 2'b10;
    localparam logic [1:0] MODE_PIPO = 2'b11;

    typedef struct packed {
        logic       cmd_ready;
        logic       busy;
        logic       rsp_valid;
        logic       reg_enable;
        logic       reg_load;
        logic       bit_strobe;
        logic       shift_tx;
        logic       shift_rx;
        logic [1:0] reg_mode;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{cmd_ready: 1'b0, busy: 1'b0, rsp_valid: 1'b0,
                                     reg_enable: 1'b0, reg_load: 1'b0, bit_strobe: 1'b0,
                                     shift_tx: 1'b0, shift_rx: 1'b0, reg_mode: MODE_PIPO};

    // Control word to be presented while the FSM sits in state s for operation op.
    function automatic ctrl_t ctrl_for(input state_t s, input op_t op);
        ctrl_t c;
        c = CTRL_RESET;
        case (s)
            S_IDLE: c.cmd_ready = 1'b1;
            S_LOAD: begin
                c.busy       = 1'b1;
                c.reg_enable = 1'b1;
                c.reg_load   = 1'b1;
                c.reg_mode   = (op == OP_TX) ? MODE_PISO : MODE_PIPO;
            end
            S_SHIFT: begin
                c.busy       = 1'b1;
                c.reg_enable = 1'b1;
                c.bit_strobe = 1'b1;
                if (op == OP_TX) begin
                    c.reg_mode = MODE_PISO;
                    c.shift_tx = 1'b1;
                end else begin
                    c.reg_mode = MODE_SR;
                    c.shift_rx = 1'b1;
                end
            end
            S_RESP: begin
                c.busy      = 1'b1;
                c.rsp_valid = 1'b1;
            end
            default: c = CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tmr_shift_ctrl_if.sv
// Command/response handshake bus between the system side and the shift sequencer.
interface tmr_shift_ctrl_if #(
    parameter int WIDTH = 128,
    parameter int LW    = $clog2(WIDTH)
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LW-1:0]    cmd_len;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_op;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op, rsp_data
    );
endinterface

// File: rtl/tmr_shift_ctrl.sv
// One-command-at-a-time sequencer driving the triplicated shift register for
// serial TX/RX of 1..WIDTH bits and parallel WRITE/READ.
module tmr_shift_ctrl
    import tmr_shift_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int LW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    tmr_shift_ctrl_if.slave  bus,
    input  logic             sin,
    output logic             sout,
    output logic             bit_strobe,
    output logic             busy,
    output logic             reg_enable,
    output logic [1:0]       reg_mode,
    output logic             reg_load,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic             reg_serial_out,
    input  logic [WIDTH-1:0] reg_parallel_out
);

    localparam logic [LW:0] WIDTH_L = (LW+1)'(WIDTH);
    localparam logic [LW:0] ONE_L   = (LW+1)'(1);

    state_t           state_r;
    op_t              op_r;
    logic [LW-1:0]    len_r;
    logic [LW:0]      cnt_r;
    ctrl_t            ctrl_r;
    logic [WIDTH-1:0] par_in_r;
    op_t              op_in_s;
    logic [LW:0]      len_eff_s;
    logic [WIDTH-1:0] rsp_data_s;

    assign op_in_s   = op_t'(bus.cmd_op);
    assign len_eff_s = (len_r == {LW{1'b0}}) ? WIDTH_L : {1'b0, len_r};

    // Sequencer FSM; the control word is registered for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            op_r     <= OP_TX;
            len_r    <= {LW{1'b0}};
            cnt_r    <= {(LW+1){1'b0}};
            ctrl_r   <= CTRL_RESET;
            par_in_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.cmd_valid && ctrl_r.cmd_ready) begin
                        op_r  <= op_in_s;
                        len_r <= bus.cmd_len;
                        cnt_r <= {(LW+1){1'b0}};
                        case (op_in_s)
                            OP_TX, OP_WRITE: begin
                                state_r  <= S_LOAD;
                                ctrl_r   <= ctrl_for(S_LOAD, op_in_s);
                                par_in_r <= bus.cmd_data;
                            end
                            OP_RX: begin
                                state_r <= S_SHIFT;
                                ctrl_r  <= ctrl_for(S_SHIFT, op_in_s);
                            end
                            OP_READ: begin
                                state_r <= S_RESP;
                                ctrl_r  <= ctrl_for(S_RESP, op_in_s);
                            end
                            default: begin
                                state_r <= S_IDLE;
                                ctrl_r  <= ctrl_for(S_IDLE, op_in_s);
                            end
                        endcase
                    end else begin
                        ctrl_r <= ctrl_for(S_IDLE, op_r);
                    end
                end
                S_LOAD: begin
                    par_in_r <= {WIDTH{1'b0}};
                    if (op_r == OP_TX) begin
                        state_r <= S_SHIFT;
                        ctrl_r  <= ctrl_for(S_SHIFT, op_r);
                    end else begin
                        state_r <= S_RESP;
                        ctrl_r  <= ctrl_for(S_RESP, op_r);
                    end
                end
                S_SHIFT: begin
                    if (cnt_r == (len_eff_s - ONE_L)) begin
                        state_r <= S_RESP;
                        cnt_r   <= {(LW+1){1'b0}};
                        ctrl_r  <= ctrl_for(S_RESP, op_r);
                    end else begin
                        cnt_r  <= cnt_r + ONE_L;
                        ctrl_r <= ctrl_for(S_SHIFT, op_r);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_r <= S_IDLE;
                        ctrl_r  <= ctrl_for(S_IDLE, op_r);
                    end else begin
                        ctrl_r <= ctrl_for(S_RESP, op_r);
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    ctrl_r   <= CTRL_RESET;
                    par_in_r <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Response word: the register holds during RESP, so this stays stable while valid.
    always_comb begin
        rsp_data_s = {WIDTH{1'b0}};
        if (ctrl_r.rsp_valid) begin
            case (op_r)
                OP_RX:   rsp_data_s = reg_parallel_out >> (WIDTH_L - len_eff_s);
                OP_READ: rsp_data_s = reg_parallel_out;
                default: rsp_data_s = {WIDTH{1'b0}};
            endcase
        end else begin
            rsp_data_s = {WIDTH{1'b0}};
        end
    end

    assign bus.cmd_ready  = ctrl_r.cmd_ready;
    assign bus.rsp_valid  = ctrl_r.rsp_valid;
    assign bus.rsp_op     = op_r;
    assign bus.rsp_data   = rsp_data_s;
    assign busy           = ctrl_r.busy;
    assign bit_strobe     = ctrl_r.bit_strobe;
    assign reg_enable     = ctrl_r.reg_enable;
    assign reg_mode       = ctrl_r.reg_mode;
    assign reg_load       = ctrl_r.reg_load;
    assign reg_parallel_in = par_in_r;
    // Serial paths pass through in the shift cycle itself, gated by registered flags.
    assign sout           = ctrl_r.shift_tx & reg_serial_out;
    assign reg_serial_in  = ctrl_r.shift_rx & sin;

endmodule

// File: tb/tb_tmr_shift_ctrl.sv
// Directed bench: controller plus a behavioural triplicated register (tb_tmr_shift_sys).
module tb_tmr_shift_ctrl;
    import tmr_shift_pkg::*;

    localparam int W  = 128;
    localparam int LW = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sin = 1'b0;
    logic sout, bit_strobe, busy, reg_enable, reg_load, reg_serial_in, reg_serial_out;
    logic [1:0]   reg_mode;
    logic [W-1:0] reg_parallel_in, reg_parallel_out;
    logic [W-1:0] cp0, cp1, cp2, nq;

    int passed = 0;
    int total  = 0;

    tmr_shift_ctrl_if #(.WIDTH(W), .LW(LW)) bus ();

    tmr_shift_ctrl #(.WIDTH(W), .LW(LW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sin(sin), .sout(sout),
        .bit_strobe(bit_strobe), .busy(busy), .reg_enable(reg_enable),
        .reg_mode(reg_mode), .reg_load(reg_load), .reg_serial_in(reg_serial_in),
        .reg_parallel_in(reg_parallel_in), .reg_serial_out(reg_serial_out),
        .reg_parallel_out(reg_parallel_out)
    );

    always #5 clk = ~clk;

    // Triplicated register with majority voter, standing in for the system register top.
    assign reg_parallel_out = (cp0 & cp1) | (cp0 & cp2) | (cp1 & cp2);
    assign reg_serial_out   = (reg_mode == MODE_SL) ? reg_parallel_out[W-1] : reg_parallel_out[0];
    always_comb begin
        nq = reg_parallel_out;
        if (reg_enable) begin
            case (reg_mode)
                MODE_SR:   nq = {reg_serial_in, reg_parallel_out[W-1:1]};
                MODE_SL:   nq = {reg_parallel_out[W-2:0], reg_serial_in};
                MODE_PISO: nq = reg_load ? reg_parallel_in : (reg_parallel_out >> 1);
                default:   nq = reg_load ? reg_parallel_in : reg_parallel_out;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cp0 <= '0; cp1 <= '0; cp2 <= '0;
        end else begin
            cp0 <= nq; cp1 <= nq; cp2 <= nq;
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", name, got, exp);
    endtask

    // Issue one command, then run until rsp_valid, feeding sin and recording sout per strobe.
    task automatic run_cmd(input logic [1:0] op, input logic [LW-1:0] len, input logic [W-1:0] data,
                           input logic [W-1:0] sin_bits, output int lat, output int strobes,
                           output logic [W-1:0] sout_bits);
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check("cmd_ready_before_issue", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_len = len; bus.cmd_data = data;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1; strobes = 0; sout_bits = '0;
        while (!bus.rsp_valid && lat < 300) begin
            if (bit_strobe && strobes < W) begin
                sin = sin_bits[strobes];
                sout_bits[strobes] = sout;
                strobes++;
            end
            @(posedge clk); #1; lat++;
        end
        sin = 1'b0;
        check("rsp_valid_within_bound", bus.rsp_valid, 1);
    endtask

    logic [W-1:0] sv, held;
    int lat, nstr, quiet;
    localparam logic [W-1:0] WORD_A = 128'hDEADBEEF_01234567_89ABCDEF_00000123;
    localparam logic [W-1:0] PAT_P  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [W-1:0] WORD_B = 128'hCAFEF00D_55AA55AA_12345678_9ABCDEF0;

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_len = '0; bus.cmd_data = '0;
        bus.rsp_ready = 1'b1;
        #12;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_reg_mode", reg_mode, 2'b11);
        check("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // WRITE then READ back
        run_cmd(2'b10, 7'd0, WORD_A, '0, lat, nstr, sv);
        check("write_latency", lat, 2);
        check("write_rsp_op", bus.rsp_op, 2'b10);
        check("write_rsp_data", bus.rsp_data, 0);
        @(posedge clk); #1;
        check("write_rsp_one_cycle", bus.rsp_valid, 0);
        run_cmd(2'b11, 7'd0, '0, '0, lat, nstr, sv);
        check("read_latency", lat, 1);
        check("read_rsp_data", bus.rsp_data, WORD_A);
        check("read_rsp_op", bus.rsp_op, 2'b11);
        @(posedge clk); #1;

        // TX 8 bits of 0xA5, LSB first
        run_cmd(2'b00, 7'd8, 128'hA5, '0, lat, nstr, sv);
        check("tx8_latency", lat, 10);
        check("tx8_strobes", nstr, 8);
        check("tx8_sout_bits", sv, 128'hA5);
        check("tx8_rsp_data", bus.rsp_data, 0);
        check("tx8_sout_idle", sout, 0);
        @(posedge clk); #1;

        // RX full width
        run_cmd(2'b01, 7'd0, '0, PAT_P, lat, nstr, sv);
        check("rx128_latency", lat, 129);
        check("rx128_strobes", nstr, 128);
        check("rx128_rsp_data", bus.rsp_data, PAT_P);
        check("rx128_strobe_off", bit_strobe, 0);
        @(posedge clk); #1;

        // RX 5 bits: 1,1,0,1,0 in arrival order
        run_cmd(2'b01, 7'd5, '0, 128'h0B, lat, nstr, sv);
        check("rx5_latency", lat, 6);
        check("rx5_strobes", nstr, 5);
        check("rx5_rsp_data", bus.rsp_data, 128'h0B);
        check("rx5_rsp_op", bus.rsp_op, 2'b01);
        @(posedge clk); #1;

        // Back-pressure on a READ response
        run_cmd(2'b10, 7'd0, WORD_B, '0, lat, nstr, sv);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        run_cmd(2'b11, 7'd0, '0, '0, lat, nstr, sv);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_data = WORD_A; bus.cmd_len = '0;
        for (int i = 0; i < 4; i++) begin
            check("bp_rsp_valid_held", bus.rsp_valid, 1);
            check("bp_rsp_data_stable", bus.rsp_data, WORD_B);
            check("bp_cmd_ready_low", bus.cmd_ready, 0);
            @(posedge clk); #1;
        end
        check("bp_still_busy", busy, 1);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs_rsp_valid", bus.rsp_valid, 0);
        check("bp_after_hs_cmd_ready", bus.cmd_ready, 1);
        check("bp_after_hs_not_busy", busy, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("bp_accepted_busy", busy, 1);
        check("bp_accepted_load", reg_load, 1);
        @(posedge clk); #1;
        check("bp_write_rsp", bus.rsp_valid, 1);
        @(posedge clk); #1;

        // Reset in the middle of a full-width TX
        check("pre_tx_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_len = '0; bus.cmd_data = '1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midtx_strobe", bit_strobe, 1);
        check("midtx_sout", sout, 1);
        #2 rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_cmd_ready", bus.cmd_ready, 0);
        check("mrst_rsp_valid", bus.rsp_valid, 0);
        check("mrst_enable", reg_enable, 0);
        check("mrst_mode", reg_mode, 2'b11);
        check("mrst_load", reg_load, 0);
        check("mrst_strobe", bit_strobe, 0);
        check("mrst_sout", sout, 0);
        check("mrst_par_in", reg_parallel_in, 0);
        check("mrst_rsp_op", bus.rsp_op, 0);
        @(negedge clk); rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || busy) quiet++;
        end
        check("mrst_no_response", quiet, 0);
        check("mrst_idle_ready", bus.cmd_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
